// File: rtl/cache_refill.sv
// Page-cache miss handler: picks a round-robin victim slot, invalidates its tag,
// copies one page byte by byte from backing memory into SRAM, then commits the tag.
module cache_refill #(
  parameter int unsigned PAGE_BITS   = 14,
  parameter int unsigned OFFSET_BITS = 10,
  parameter int unsigned SLOT_BITS   = 2
) (
  input  logic                             fpgaClk,
  input  logic                             resetN,
  input  logic                             miss_req,
  input  logic [PAGE_BITS-1:0]             miss_page,
  output logic                             fill_busy,
  output logic                             fill_done,
  output logic [SLOT_BITS-1:0]             fill_slot,
  output logic                             tag_we,
  output logic [SLOT_BITS-1:0]             tag_slot,
  output logic [PAGE_BITS-1:0]             tag_page,
  output logic                             tag_valid,
  output logic                             mem_req,
  output logic [PAGE_BITS+OFFSET_BITS-1:0] mem_addr,
  input  logic                             mem_ack,
  input  logic [7:0]                       mem_data,
  output logic                             sram_ce,
  output logic                             sram_we,
  output logic [SLOT_BITS+OFFSET_BITS-1:0] sram_addr,
  output logic [7:0]                       sram_data
);

  localparam int unsigned MemAddrW  = PAGE_BITS + OFFSET_BITS;
  localparam int unsigned SramAddrW = SLOT_BITS + OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE, INVAL, FETCH, WRITE, COMMIT, DONE, RELEASE
  } state_e;

  state_e                 state_q, state_d;
  logic [PAGE_BITS-1:0]   page_q, page_d;
  logic [SLOT_BITS-1:0]   slot_q, slot_d;
  logic [SLOT_BITS-1:0]   victim_q, victim_d;
  logic [OFFSET_BITS-1:0] off_q, off_d;
  logic [7:0]             data_q, data_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tag_we_q, tag_we_d;
  logic                   tag_valid_q, tag_valid_d;
  logic [SLOT_BITS-1:0]   tag_slot_q, tag_slot_d;
  logic [PAGE_BITS-1:0]   tag_page_q, tag_page_d;
  logic                   mem_req_q, mem_req_d;
  logic [MemAddrW-1:0]    mem_addr_q, mem_addr_d;
  logic                   sram_ce_q, sram_ce_d;
  logic                   sram_we_q, sram_we_d;
  logic [SramAddrW-1:0]   sram_addr_q, sram_addr_d;
  logic [7:0]             sram_data_q, sram_data_d;

  // Next state and datapath; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    slot_d   = slot_q;
    victim_d = victim_q;
    off_d    = off_q;
    data_d   = data_q;

    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          page_d  = miss_page;
          slot_d  = victim_q;
          off_d   = '0;
          state_d = INVAL;
        end
      end
      INVAL: state_d = FETCH;
      FETCH: begin
        if (mem_ack) begin
          data_d  = mem_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (&off_q) begin
          state_d = COMMIT;
        end else begin
          off_d   = OFFSET_BITS'(off_q + 1'b1);
          state_d = FETCH;
        end
      end
      COMMIT: begin
        victim_d = SLOT_BITS'(victim_q + 1'b1);
        state_d  = DONE;
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        if (!miss_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    tag_we_d    = (state_d == INVAL) || (state_d == COMMIT);
    tag_valid_d = (state_d == COMMIT);
    tag_slot_d  = tag_we_d ? slot_d : tag_slot_q;
    tag_page_d  = tag_we_d ? page_d : tag_page_q;
    mem_req_d   = (state_d == FETCH);
    mem_addr_d  = mem_req_d ? {page_d, off_d} : mem_addr_q;
    sram_ce_d   = (state_d == WRITE);
    sram_we_d   = (state_d == WRITE);
    sram_addr_d = sram_we_d ? {slot_d, off_d} : sram_addr_q;
    sram_data_d = sram_we_d ? data_d : sram_data_q;
  end

  // State, datapath and output registers; reset aborts any fill without a commit.
  always_ff @(posedge fpgaClk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      page_q      <= '0;
      slot_q      <= '0;
      victim_q    <= '0;
      off_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_we_q    <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_slot_q  <= '0;
      tag_page_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      sram_ce_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      slot_q      <= slot_d;
      victim_q    <= victim_d;
      off_q       <= off_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tag_we_q    <= tag_we_d;
      tag_valid_q <= tag_valid_d;
      tag_slot_q  <= tag_slot_d;
      tag_page_q  <= tag_page_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      sram_ce_q   <= sram_ce_d;
      sram_we_q   <= sram_we_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
    end
  end

  assign fill_busy = busy_q;
  assign fill_done = done_q;
  assign fill_slot = slot_q;
  assign tag_we    = tag_we_q;
  assign tag_valid = tag_valid_q;
  assign tag_slot  = tag_slot_q;
  assign tag_page  = tag_page_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign sram_ce   = sram_ce_q;
  assign sram_we   = sram_we_q;
  assign sram_addr = sram_addr_q;
  assign sram_data = sram_data_q;

endmodule
